// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC generation, in-order imem requests, response
// buffering, and redirect handling for the IF/ID pipeline register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        nop_out,
  output logic        instr_valid
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam int unsigned PW        = $clog2(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   cred_t;
  typedef logic [PW-1:0] ptr_t;

  localparam cred_t DEPTH_C = cred_t'(DEPTH);

  logic [31:0] fetch_pc;
  cnt_t        outstanding;
  cnt_t        discard;
  cnt_t        fifo_count;
  ptr_t        tag_wr;
  ptr_t        tag_rd;
  ptr_t        fifo_wr;
  ptr_t        fifo_rd;

  logic [31:0] tag_q      [DEPTH];
  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];

  cred_t credit;
  logic  head_valid;
  logic  gnt_fire;
  logic  rsp_fire;
  logic  rsp_drop;
  logic  push;
  logic  pop;

  // Low address bits of the redirect target are forced to zero.
  logic redirect_low_unused;
  assign redirect_low_unused = ^redirect_pc[1:0];

  // Request credit, output presentation and per-cycle event decode.
  always_comb begin
    credit      = cred_t'(outstanding) + cred_t'(fifo_count);
    head_valid  = (fifo_count != '0) && !redirect_valid;
    imem_req    = rst_n && !redirect_valid && (credit < DEPTH_C);
    imem_addr   = fetch_pc;
    nop_out     = !head_valid;
    instr_valid = head_valid;
    instr_out   = head_valid ? fifo_instr[fifo_rd] : NOP_INSTR;
    pc_out      = head_valid ? fifo_pc[fifo_rd] : '0;
    gnt_fire    = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol violation and is ignored.
    rsp_fire    = imem_rvalid && (outstanding != '0);
    rsp_drop    = rsp_fire && (discard != '0);
    push        = rsp_fire && !rsp_drop && !redirect_valid;
    pop         = head_valid && !stall;
  end

  // Control state: fetch PC, counters and queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
    end else begin
      outstanding <= outstanding + cnt_t'(gnt_fire) - cnt_t'(rsp_fire);
      if (gnt_fire) begin
        tag_wr   <= tag_wr + ptr_t'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp_fire) begin
        tag_rd <= tag_rd + ptr_t'(1);
      end
      if (redirect_valid) begin
        // Every request still pending after this cycle's retirement is wrong-path.
        fetch_pc   <= {redirect_pc[31:2], 2'b00};
        discard    <= outstanding - cnt_t'(rsp_fire);
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
      end else begin
        if (rsp_drop) begin
          discard <= discard - cnt_t'(1);
        end
        if (push) begin
          fifo_wr <= fifo_wr + ptr_t'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + ptr_t'(1);
        end
        fifo_count <= fifo_count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // Storage for request tags and buffered {pc, instr} entries.
  always_ff @(posedge clk) begin
    if (gnt_fire) begin
      tag_q[tag_wr] <= fetch_pc;
    end
    if (push) begin
      fifo_pc[fifo_wr]    <= tag_q[tag_rd];
      fifo_instr[fifo_wr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every
// cycle, a latency-programmable in-order memory, and directed scenarios
// with literal expectations.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        nop_out;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [31:0] pc; bit drop;}          tag_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  typedef struct {int unsigned ready; logic [31:0] data;} mem_t;

  tag_t infl[$];
  ent_t outq[$];
  mem_t memq[$];
  logic [31:0] mpc = RESET_PC;
  int unsigned lat = 1;
  int unsigned cyc = 0;
  logic        mem_nv = 1'b0;
  logic [31:0] mem_nd = '0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .nop_out(nop_out),
    .instr_valid(instr_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    imem_rvalid = mem_nv;
    imem_rdata  = mem_nd;
  endtask

  // Reference model and memory: compare on negedge, then advance to post-edge state.
  always @(negedge clk) begin
    int   credit;
    logic e_req, e_valid, pop_o;
    tag_t t;
    ent_t e;
    mem_t m;
    credit  = infl.size() + outq.size();
    e_req   = rst_n && !redirect_valid && (credit < DEPTH);
    e_valid = rst_n && !redirect_valid && (outq.size() > 0);
    check("m_req", imem_req, e_req);
    check("m_nop", nop_out, !e_valid);
    check("m_valid", instr_valid, e_valid);
    check("m_instr", instr_out, e_valid ? outq[0].instr : NOP);
    check("m_pc", pc_out, e_valid ? outq[0].pc : 32'h0);
    if (e_req) check("m_addr", imem_addr, mpc);

    if (!rst_n) begin
      infl.delete();
      outq.delete();
      memq.delete();
      mpc    = RESET_PC;
      mem_nv = 1'b0;
      mem_nd = '0;
    end else begin
      pop_o = e_valid && !stall;
      if (pop_o) void'(outq.pop_front());
      if (imem_rvalid && infl.size() > 0) begin
        t = infl.pop_front();
        if (!t.drop && !redirect_valid) begin
          e.pc    = t.pc;
          e.instr = imem_rdata;
          outq.push_back(e);
        end
      end
      if (redirect_valid) begin
        outq.delete();
        for (int i = 0; i < infl.size(); i++) begin
          t = infl[i];
          t.drop = 1'b1;
          infl[i] = t;
        end
        mpc = redirect_pc & 32'hFFFF_FFFC;
      end else if (e_req && imem_gnt) begin
        t.pc   = mpc;
        t.drop = 1'b0;
        infl.push_back(t);
        mpc = mpc + 32'd4;
      end
      if (imem_req && imem_gnt) begin
        m.ready = cyc + lat;
        m.data  = imem_addr ^ KEY;
        memq.push_back(m);
      end
      if (memq.size() > 0 && memq[0].ready <= cyc + 1) begin
        m      = memq.pop_front();
        mem_nv = 1'b1;
        mem_nd = m.data;
      end else begin
        mem_nv = 1'b0;
        mem_nd = '0;
      end
    end
    cyc++;
  end

  initial begin
    logic [31:0] hold_pc, hold_instr, x;
    int gnts, seen;
    bit found;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset state
    step(); step(); #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_nop", nop_out, 1'b1);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr_out, NOP);
    check("rst_pc", pc_out, 32'h0);

    // Release: first fetches and 2-cycle gnt-to-output latency
    step(); rst_n = 1'b1; #1;
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h0);
    step(); #1;
    check("second_addr", imem_addr, 32'h4);
    check("nop_before_first", nop_out, 1'b1);
    step(); #1;
    check("first_nop", nop_out, 1'b0);
    check("first_pc", pc_out, 32'h0);
    check("first_instr", instr_out, 32'hA5A5_0000);
    check("credit_full_req", imem_req, 1'b0);
    for (int i = 0; i < 6; i++) step();

    // Stall for 5 cycles
    stall = 1'b1; gnts = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (imem_req && imem_gnt) gnts++;
      if (i == 2) begin hold_pc = pc_out; hold_instr = instr_out; end
      if (i > 2) begin
        check("stall_pc_hold", pc_out, hold_pc);
        check("stall_instr_hold", instr_out, hold_instr);
        check("stall_nop", nop_out, 1'b0);
      end
      if (i == 4) check("stall_req_off", imem_req, 1'b0);
      step();
    end
    stall = 1'b0;
    check("stall_gnts_le_depth", gnts <= DEPTH, 1'b1);
    for (int i = 0; i < 6; i++) step();

    // Drain, then redirect with two requests outstanding
    imem_gnt = 1'b0;
    for (int i = 0; i < 6; i++) step();
    lat = 3; imem_gnt = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    check("redir_req_off", imem_req, 1'b0);
    check("redir_nop", nop_out, 1'b1);
    step(); redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1; if (imem_req) found = 1; else step();
    end
    check("redir_req_seen", found, 1'b1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1; if (!nop_out) found = 1; else step();
    end
    check("redir_out_seen", found, 1'b1);
    check("redir_pc", pc_out, 32'h0000_0100);
    check("redir_instr", instr_out, 32'hA5A5_0100);

    // Back-to-back redirects: the later target wins
    for (int i = 0; i < 4; i++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step(); redirect_pc = 32'h0000_0400;
    step(); redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      #1; if (!nop_out) found = 1; else step();
    end
    check("b2b_out_seen", found, 1'b1);
    check("b2b_pc", pc_out, 32'h0000_0400);

    // Reset in mid-stream
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0; #1;
    check("midrst_req", imem_req, 1'b0);
    check("midrst_nop", nop_out, 1'b1);
    check("midrst_instr", instr_out, NOP);
    step(); step();
    rst_n = 1'b1; lat = 1; #1;
    check("midrst_restart_addr", imem_addr, RESET_PC);
    check("midrst_restart_req", imem_req, 1'b1);
    for (int i = 0; i < 8; i++) step();

    // Redirect coinciding with the response of a pending request
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1; if (imem_req && imem_gnt) found = 1; else step();
    end
    check("samecyc_gnt_seen", found, 1'b1);
    x = imem_addr;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
    check("samecyc_req_off", imem_req, 1'b0);
    step(); redirect_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      #1; if (!nop_out && pc_out == x) seen++;
      step();
    end
    check("samecyc_pc_absent", seen, 0);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step(); redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1; if (imem_req && imem_gnt) found = 1; else step();
    end
    check("wrap_gnt_seen", found, 1'b1);
    check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    step(); #1;
    check("wrap_req", imem_req, 1'b1);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) step();

    // Stray rvalid with nothing outstanding is ignored
    imem_gnt = 1'b0;
    for (int i = 0; i < 6; i++) step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step(); #1;
    check("stray_nop", nop_out, 1'b1);
    imem_gnt = 1'b1;
    for (int i = 0; i < 6; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
